// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART receiver:
//   OVERSAMPLE            - b_tick strobes per serial bit period
//   PAR_NONE/EVEN/ODD     - parity-mode encodings used by the PARITY parameter
//   rx_state_e            - receiver FSM state encoding
//   maj3()                - 2-of-3 majority vote
//   parity_mismatch()     - turns the data^parity XOR into an error flag
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // xor_all is the XOR of all data bits and the received parity bit.
  // Even parity expects 0 there, odd parity expects 1.
  function automatic logic parity_mismatch(input logic xor_all, input int mode);
    logic mismatch;
    if (mode == PAR_ODD) begin
      mismatch = ~xor_all;
    end else if (mode == PAR_EVEN) begin
      mismatch = xor_all;
    end else begin
      mismatch = 1'b0;
    end
    return mismatch;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// -----------------------------------------------------------------------------
// uart_bit_sampler
// Synchronises the asynchronous rx line (2 flops, reset to idle-high) and
// captures three samples of the synchronised line at tick counts 7, 8 and 9
// of the current bit period. voted_bit is the majority of those samples and is
// stable by tick 15, where the receiver FSM consumes it.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   rx         - raw serial input
//   sample_en  - b_tick qualified by "receiver inside a frame"
//   tick_cnt   - current 0..15 tick position within the bit
//   rx_sync    - synchronised rx
//   voted_bit  - majority of the three mid-bit samples
// -----------------------------------------------------------------------------
module uart_bit_sampler
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       sample_en,
  input  logic [3:0] tick_cnt,
  output logic       rx_sync,
  output logic       voted_bit
);

  logic sync1_q, sync2_q;
  logic s7_q, s8_q, s9_q;
  logic s7_d, s8_d, s9_d;

  // Two-flop synchroniser; idle-high reset so a reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Select which mid-bit sample register captures on this tick.
  always_comb begin
    s7_d = s7_q;
    s8_d = s8_q;
    s9_d = s9_q;
    if (sample_en) begin
      case (tick_cnt)
        4'd7:    s7_d = sync2_q;
        4'd8:    s8_d = sync2_q;
        4'd9:    s9_d = sync2_q;
        default: begin
          s7_d = s7_q;
          s8_d = s8_q;
          s9_d = s9_q;
        end
      endcase
    end else begin
      s7_d = s7_q;
      s8_d = s8_q;
      s9_d = s9_q;
    end
  end

  // Mid-bit sample registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s7_q <= 1'b1;
      s8_q <= 1'b1;
      s9_q <= 1'b1;
    end else begin
      s7_q <= s7_d;
      s8_q <= s8_d;
      s9_q <= s9_d;
    end
  end

  assign rx_sync   = sync2_q;
  assign voted_bit = maj3(s7_q, s8_q, s9_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
// 16x-oversampled UART receiver with configurable data width, parity and
// number of checked stop bits.
// Parameters:
//   DATA_BITS  5..9 data bits per frame
//   PARITY     PAR_NONE / PAR_EVEN / PAR_ODD
//   STOP_BITS  1 or 2 checked stop bits
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   b_tick      - one-clk strobe at 16x bit rate
//   rx          - asynchronous serial line, idle high
//   rx_data     - last received word, LSB = first data bit
//   rx_done     - one-clk pulse when a frame completes
//   parity_err  - parity mismatch in last frame (0 when PARITY = PAR_NONE)
//   frame_err   - a checked stop bit was low in last frame
//   break_det   - every data/parity/stop sample of last frame was low
//   rx_busy     - receiver not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 rx_busy
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [3:0]           tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [1:0]           stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 ferr_pend_q, ferr_pend_d;
  logic                 all_low_q, all_low_d;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 break_det_q, break_det_d;
  logic                 rx_busy_q, rx_busy_d;

  logic                 rx_sync;
  logic                 voted_bit;
  logic                 in_frame;
  logic                 sample_en;
  logic                 tick_end;
  logic                 ferr_now;
  logic                 low_now;

  // b_tick only matters while a frame is being timed; IDLE and WAIT_IDLE ignore it.
  assign in_frame  = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign sample_en = b_tick & in_frame;
  assign tick_end  = sample_en & (tick_q == TICK_LAST);

  uart_bit_sampler u_sampler (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .sample_en (sample_en),
    .tick_cnt  (tick_q),
    .rx_sync   (rx_sync),
    .voted_bit (voted_bit)
  );

  // Next-state, datapath and output-register logic of the receiver FSM.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    stop_d       = stop_q;
    shift_d      = shift_q;
    perr_pend_d  = perr_pend_q;
    ferr_pend_d  = ferr_pend_q;
    all_low_d    = all_low_q;
    rx_data_d    = rx_data_q;
    rx_done_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;

    // Accumulated error / break status including the bit resolved this tick.
    ferr_now = ferr_pend_q | ~voted_bit;
    low_now  = all_low_q & ~voted_bit;

    if (sample_en) begin
      if (tick_q == TICK_LAST) begin
        tick_d = 4'd0;
      end else begin
        tick_d = tick_q + 4'd1;
      end
    end else begin
      tick_d = tick_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_sync) begin
          state_d     = ST_START;
          tick_d      = 4'd0;
          bit_d       = 4'd0;
          stop_d      = 2'd0;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
          all_low_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (tick_end) begin
          // A voted 1 means the low level was noise: drop back silently.
          if (!voted_bit) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end

      ST_DATA: begin
        if (tick_end) begin
          // Right shift with insert at MSB leaves the first bit at the LSB.
          shift_d   = {voted_bit, shift_q[DATA_BITS-1:1]};
          all_low_d = low_now;
          if (bit_q == BIT_LAST) begin
            bit_d = 4'd0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
            end else begin
              state_d = ST_STOP;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_PARITY: begin
        if (tick_end) begin
          perr_pend_d = parity_mismatch((^shift_q) ^ voted_bit, PARITY);
          all_low_d   = low_now;
          state_d     = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end

      ST_STOP: begin
        if (tick_end) begin
          ferr_pend_d = ferr_now;
          all_low_d   = low_now;
          if (stop_q == STOP_LAST) begin
            stop_d    = 2'd0;
            rx_done_d = 1'b1;
            rx_data_d = shift_q;
            if (PARITY == PAR_NONE) begin
              parity_err_d = 1'b0;
            end else begin
              parity_err_d = perr_pend_q;
            end
            frame_err_d = ferr_now;
            break_det_d = low_now;
            // After a framing error the line may still be held low (break);
            // wait for it to go high before hunting for a new start bit.
            if (ferr_now) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = stop_q + 2'd1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end

      ST_WAIT_IDLE: begin
        if (rx_sync) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rx_busy_d = (state_d != ST_IDLE);
  end

  // State, counters, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_q       <= 4'd0;
      bit_q        <= 4'd0;
      stop_q       <= 2'd0;
      shift_q      <= '0;
      perr_pend_q  <= 1'b0;
      ferr_pend_q  <= 1'b0;
      all_low_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      shift_q      <= shift_d;
      perr_pend_q  <= perr_pend_d;
      ferr_pend_q  <= ferr_pend_d;
      all_low_q    <= all_low_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
      rx_busy_q    <= rx_busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_done    = rx_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;
  assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cfg
// Three receiver configurations share clk, rst and b_tick (b_tick high every
// other clk). Each has its own rx line. Expected frames are queued when sent
// and checked by a per-instance monitor on every rx_done pulse.
//   u_a : DATA_BITS 8, no parity, 1 stop
//   u_b : DATA_BITS 7, even parity, 1 stop
//   u_c : DATA_BITS 8, no parity, 2 stops
// -----------------------------------------------------------------------------
module tb_uart_rx_cfg;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       b_tick;
  logic       rx_a, rx_b, rx_c;
  logic [7:0] data_a, data_c;
  logic [6:0] data_b;
  logic       done_a, perr_a, ferr_a, brk_a, busy_a;
  logic       done_b, perr_b, ferr_b, brk_b, busy_b;
  logic       done_c, perr_c, ferr_c, brk_c, busy_c;
  logic       prev_a, prev_b, prev_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .b_tick(b_tick), .rx(rx_a), .rx_data(data_a),
    .rx_done(done_a), .parity_err(perr_a), .frame_err(ferr_a),
    .break_det(brk_a), .rx_busy(busy_a)
  );

  uart_rx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .b_tick(b_tick), .rx(rx_b), .rx_data(data_b),
    .rx_done(done_b), .parity_err(perr_b), .frame_err(ferr_b),
    .break_det(brk_b), .rx_busy(busy_b)
  );

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .b_tick(b_tick), .rx(rx_c), .rx_data(data_c),
    .rx_done(done_c), .parity_err(perr_c), .frame_err(ferr_c),
    .break_det(brk_c), .rx_busy(busy_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    b_tick = 1'b0;
    forever begin
      @(negedge clk);
      b_tick = ~b_tick;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f, input logic b);
    exp_t e;
    e.data = d;
    e.perr = p;
    e.ferr = f;
    e.brk  = b;
    return e;
  endfunction

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (b_tick !== 1'b1);
    end
  endtask

  task automatic drive(input int ch, input logic v);
    @(negedge clk);
    case (ch)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send_bit(input int ch, input logic v);
    drive(ch, v);
    wait_ticks(16);
  endtask

  // glitch_bit >= 0 inverts that data bit for one tick in mid-bit.
  task automatic send_frame(input int ch, input logic [8:0] data, input int nbits,
                            input int par_en, input logic par_bit,
                            input logic [1:0] stops, input int nstops,
                            input int glitch_bit);
    send_bit(ch, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_bit) begin
        drive(ch, data[i]);
        wait_ticks(8);
        drive(ch, ~data[i]);
        wait_ticks(1);
        drive(ch, data[i]);
        wait_ticks(7);
      end else begin
        send_bit(ch, data[i]);
      end
    end
    if (par_en != 0) send_bit(ch, par_bit);
    for (int i = 0; i < nstops; i++) send_bit(ch, stops[i]);
  endtask

  // Scoreboard monitor for u_a.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (done_a === 1'b1) begin
      chk("a_done_pulse", 32'(prev_a), 32'd0);
      chk("a_done_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("a_data", 32'(data_a), 32'(e.data));
        chk("a_parity_err", 32'(perr_a), 32'(e.perr));
        chk("a_frame_err", 32'(ferr_a), 32'(e.ferr));
        chk("a_break_det", 32'(brk_a), 32'(e.brk));
      end
    end
    prev_a <= done_a;
  end

  // Scoreboard monitor for u_b.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (done_b === 1'b1) begin
      chk("b_done_pulse", 32'(prev_b), 32'd0);
      chk("b_done_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("b_data", 32'(data_b), 32'(e.data));
        chk("b_parity_err", 32'(perr_b), 32'(e.perr));
        chk("b_frame_err", 32'(ferr_b), 32'(e.ferr));
        chk("b_break_det", 32'(brk_b), 32'(e.brk));
      end
    end
    prev_b <= done_b;
  end

  // Scoreboard monitor for u_c.
  always @(negedge clk) begin : mon_c
    exp_t e;
    if (done_c === 1'b1) begin
      chk("c_done_pulse", 32'(prev_c), 32'd0);
      chk("c_done_expected", 32'(q_c.size() != 0), 32'd1);
      if (q_c.size() != 0) begin
        e = q_c.pop_front();
        chk("c_data", 32'(data_c), 32'(e.data));
        chk("c_parity_err", 32'(perr_c), 32'(e.perr));
        chk("c_frame_err", 32'(ferr_c), 32'(e.ferr));
        chk("c_break_det", 32'(brk_c), 32'(e.brk));
      end
    end
    prev_c <= done_c;
  end

  initial begin
    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    rx_c = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_a_data", 32'(data_a), 32'h0);
    chk("rst_a_done", 32'(done_a), 32'h0);
    chk("rst_a_flags", 32'({perr_a, ferr_a, brk_a}), 32'h0);
    chk("rst_a_busy", 32'(busy_a), 32'h0);
    chk("rst_b_all", 32'({data_b, done_b, perr_b, ferr_b, brk_b, busy_b}), 32'h0);
    chk("rst_c_all", 32'({data_c, done_c, perr_c, ferr_c, brk_c, busy_c}), 32'h0);
    rst = 1'b0;
    wait_ticks(4);

    // Clean default frame.
    q_a.push_back(mk(9'h0A5, 1'b0, 1'b0, 1'b0));
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b01, 1, -1);
    wait_ticks(40);
    chk("a5_busy_idle", 32'(busy_a), 32'h0);

    // Short low glitch: false start, nothing changes.
    drive(0, 1'b0);
    wait_ticks(4);
    drive(0, 1'b1);
    wait_ticks(2);
    chk("glitch_busy_start", 32'(busy_a), 32'h1);
    wait_ticks(24);
    chk("glitch_busy_idle", 32'(busy_a), 32'h0);
    chk("glitch_data_held", 32'(data_a), 32'hA5);
    chk("glitch_flags_held", 32'({perr_a, ferr_a, brk_a}), 32'h0);

    // One-tick glitch in the middle of data bit 3 is voted away.
    q_a.push_back(mk(9'h096, 1'b0, 1'b0, 1'b0));
    send_frame(0, 9'h096, 8, 0, 1'b0, 2'b01, 1, 3);
    wait_ticks(40);
    q_a.push_back(mk(9'h069, 1'b0, 1'b0, 1'b0));
    send_frame(0, 9'h069, 8, 0, 1'b0, 2'b01, 1, 0);
    wait_ticks(40);

    // Break: 20 bit periods low gives exactly one frame with all flags.
    q_a.push_back(mk(9'h000, 1'b0, 1'b1, 1'b1));
    drive(0, 1'b0);
    wait_ticks(320);
    chk("break_busy_wait_idle", 32'(busy_a), 32'h1);
    chk("break_queue_drained", 32'(q_a.size()), 32'd0);
    drive(0, 1'b1);
    wait_ticks(4);
    chk("break_busy_released", 32'(busy_a), 32'h0);
    chk("break_flags_held", 32'({ferr_a, brk_a}), 32'h3);
    wait_ticks(20);

    // Reset during data bit 3 aborts the frame.
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    drive(0, 1'b1);
    wait_ticks(8);
    chk("pre_rst_busy", 32'(busy_a), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_data", 32'(data_a), 32'h0);
    chk("midrst_done", 32'(done_a), 32'h0);
    chk("midrst_flags", 32'({perr_a, ferr_a, brk_a}), 32'h0);
    chk("midrst_busy", 32'(busy_a), 32'h0);
    rst = 1'b0;
    wait_ticks(8);
    q_a.push_back(mk(9'h081, 1'b0, 1'b0, 1'b0));
    send_frame(0, 9'h081, 8, 0, 1'b0, 2'b01, 1, -1);
    wait_ticks(40);

    // Even parity, 7 data bits.
    q_b.push_back(mk(9'h041, 1'b1, 1'b0, 1'b0));
    send_frame(1, 9'h041, 7, 1, 1'b1, 2'b01, 1, -1);
    wait_ticks(40);
    q_b.push_back(mk(9'h041, 1'b0, 1'b0, 1'b0));
    send_frame(1, 9'h041, 7, 1, 1'b0, 2'b01, 1, -1);
    wait_ticks(40);
    q_b.push_back(mk(9'h043, 1'b0, 1'b0, 1'b0));
    send_frame(1, 9'h043, 7, 1, 1'b1, 2'b01, 1, -1);
    wait_ticks(40);
    q_b.push_back(mk(9'h043, 1'b1, 1'b0, 1'b0));
    send_frame(1, 9'h043, 7, 1, 1'b0, 2'b01, 1, -1);
    wait_ticks(40);

    // Two stop bits, second one low: frame error, then WAIT_IDLE.
    q_c.push_back(mk(9'h03C, 1'b0, 1'b1, 1'b0));
    send_frame(2, 9'h03C, 8, 0, 1'b0, 2'b01, 2, -1);
    wait_ticks(24);
    chk("s2_busy_wait_idle", 32'(busy_c), 32'h1);
    chk("s2_ferr_held", 32'(ferr_c), 32'h1);
    drive(2, 1'b1);
    wait_ticks(4);
    chk("s2_busy_released", 32'(busy_c), 32'h0);
    q_c.push_back(mk(9'h055, 1'b0, 1'b0, 1'b0));
    send_frame(2, 9'h055, 8, 0, 1'b0, 2'b11, 2, -1);
    wait_ticks(40);

    chk("end_q_a_empty", 32'(q_a.size()), 32'd0);
    chk("end_q_b_empty", 32'(q_b.size()), 32'd0);
    chk("end_q_c_empty", 32'(q_c.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-002 Parameter PARITY, default 0: parity mode; 0 = none, 1 = even, 2 = odd.
REQ-003 Parameter STOP_BITS, default 1: stop bits checked per frame; legal values 1, 2.
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 b_tick  input  1  one-clk baud strobe at 16x the bit rate.
REQ-007 rx  input  1  asynchronous serial line; idle high.
REQ-008 rx_data  output  DATA_BITS  last received word, LSB = first data bit.
REQ-009 rx_done  output  1  one-clk pulse: frame complete; rx_data and flags valid.
REQ-010 parity_err  output  1  parity mismatch in last frame; forced 0 when PARITY = 0.
REQ-011 frame_err  output  1  any checked stop bit sampled low in last frame.
REQ-012 break_det  output  1  last frame: all data, parity and stop samples low.
REQ-013 rx_busy  output  1  high in every state except IDLE.

Function
REQ-014 rx passes through a 2-flop synchroniser before any use; added latency is 2 clk.
REQ-015 Each bit period is 16 b_ticks, counted 0..15 by a 4-bit tick counter. The counter advances only on b_tick.
REQ-016 Bit value is the majority of the synchronised rx sampled at tick counts 7, 8 and 9. It is resolved at tick count 15.
REQ-017 States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-018 IDLE: on synchronised rx = 0, go to START and clear the tick, bit and stop counters.
REQ-019 START: at tick 15, a voted 0 goes to DATA; a voted 1 is a false start and goes to IDLE with no rx_done and no flag change.
REQ-020 DATA: shift each voted bit in at the MSB, right-shifting, so that after DATA_BITS bits the first bit sits at the LSB. After bit DATA_BITS-1, go to PARITY if PARITY != 0, else to STOP.
REQ-021 PARITY: the voted bit is XORed with the XOR of the data. Mismatch means the result is 1 for even parity and 0 for odd. Then go to STOP.
REQ-022 STOP: check STOP_BITS consecutive bit periods. Any voted 0 sets the pending frame error.
REQ-023 End of the last stop bit (tick 15): in the next clk, rx_done = 1 for exactly one cycle. In that same cycle rx_data, parity_err, frame_err and break_det are updated together.
REQ-024 After a clean frame, go to IDLE. After a frame error, go to WAIT_IDLE.
REQ-025 WAIT_IDLE: stay until synchronised rx = 1, then go to IDLE. This prevents retriggering during a break.
REQ-026 rx_data and the flags hold their values until the next rx_done. A false start does not alter them.
REQ-027 b_tick is ignored in IDLE and WAIT_IDLE.
REQ-028 If b_tick is held high continuously, each clk counts as one tick. The FSM has no other dependence on the clk-to-tick ratio.

Reset
REQ-029 Asserting rst at any time, including mid-frame, aborts the frame immediately with no rx_done.
REQ-030 Reset values: state IDLE; all counters 0; rx_data 0; rx_done, parity_err, frame_err, break_det and rx_busy 0; synchroniser flops 1.
REQ-031 After rst deasserts, a low rx is treated as a new start bit.

Structure
REQ-032 Shared package uart_pkg holds: OVERSAMPLE = 16, the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the rx state encoding.
REQ-033 One sub-module, uart_bit_sampler, contains the synchroniser and the 3-sample majority voter. It outputs rx_sync and voted_bit.
REQ-034 Expected size of the top-level FSM plus datapath: 150-300 lines.

Verification
REQ-035 Defaults; send 0xA5 with 1 stop bit -> one rx_done pulse, rx_data = 0xA5, all flags 0.
REQ-036 PARITY = 1, DATA_BITS = 7; send 0x41 with parity bit 1 -> rx_data = 0x41, parity_err = 1. Repeat with parity bit 0 -> parity_err = 0.
REQ-037 STOP_BITS = 2; send 0x3C with second stop bit low -> frame_err = 1, FSM enters WAIT_IDLE. A new 0x55 frame after the line returns high -> rx_data = 0x55, frame_err = 0.
REQ-038 Hold rx low for 20 bit periods -> one rx_done with rx_data = 0, break_det = 1, frame_err = 1. No further rx_done until rx goes high.
REQ-039 Glitch rx low for 4 ticks only -> false start, no rx_done, rx_data unchanged, rx_busy returns to 0. Separately, a one-tick glitch at tick 8 of a data bit -> data unaffected by the majority vote.
REQ-040 Assert rst during data bit 3 of a frame -> all outputs reset values. The next complete frame 0x81 -> rx_data = 0x81.
